// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM/WB operand bypass, load-use stall and flush-across-hold.
// Optional hazard counters are enabled by defining ID_EX_HAZARD_STATS_EN.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_ra1,
  input  logic [AW-1:0]   id_ra2,
  input  logic            id_use1,
  input  logic            id_use2,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [AW-1:0]   id_wa,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [OPW-1:0]  id_alu_op,
  input  logic            id_reg_we,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic [XLEN-1:0] alu_result,
  input  logic            mem_valid,
  input  logic            mem_reg_we,
  input  logic [AW-1:0]   mem_wa,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_valid,
  input  logic            wb_reg_we,
  input  logic [AW-1:0]   wb_wa,
  input  logic [XLEN-1:0] wb_result,
  input  logic            ex_hold,
  input  logic            flush,
  output logic            stall_id,
  output logic            ex_valid,
  output logic            ex_reg_we,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic [AW-1:0]   ex_wa,
  output logic [OPW-1:0]  ex_alu_op,
  output logic [XLEN-1:0] ex_opa,
  output logic [XLEN-1:0] ex_opb,
  output logic [XLEN-1:0] ex_store_data
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [31:0]     stat_lu_cnt,
  output logic [31:0]     stat_flush_cnt
`endif
);

  logic            flush_pend;
  logic            lu;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] opb_next;

  // Youngest producer wins; a load in EX has no data yet, so it is excluded here and caught by lu.
  function automatic logic [XLEN-1:0] resolve(input logic [AW-1:0] s, input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] r;
    r = rd;
    if (s == '0)
      r = '0;
    else if (ex_valid && ex_reg_we && ex_wa == s && !ex_mem_rd)
      r = alu_result;
    else if (mem_valid && mem_reg_we && mem_wa == s)
      r = mem_result;
    else if (wb_valid && wb_reg_we && wb_wa == s)
      r = wb_result;
    return r;
  endfunction

  always_comb begin
    src1     = resolve(id_ra1, id_rd1);
    src2     = resolve(id_ra2, id_rd2);
    opb_next = id_use_imm ? id_imm : src2;
    lu       = id_valid && ex_valid && ex_mem_rd && (ex_wa != '0) &&
               ((id_use1 && ex_wa == id_ra1) || (id_use2 && ex_wa == id_ra2));
    stall_id = ex_hold | lu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend    <= 1'b0;
      ex_valid      <= 1'b0;
      ex_reg_we     <= 1'b0;
      ex_mem_rd     <= 1'b0;
      ex_mem_wr     <= 1'b0;
      ex_wa         <= '0;
      ex_alu_op     <= '0;
      ex_opa        <= '0;
      ex_opb        <= '0;
      ex_store_data <= '0;
    end else if (ex_hold) begin
      if (flush)
        flush_pend <= 1'b1;
    end else if (flush || flush_pend || lu) begin
      // Bubble: control cleared, data fields left as they were.
      flush_pend <= 1'b0;
      ex_valid   <= 1'b0;
      ex_reg_we  <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
    end else begin
      ex_valid      <= id_valid;
      ex_reg_we     <= id_valid & id_reg_we;
      ex_mem_rd     <= id_valid & id_mem_rd;
      ex_mem_wr     <= id_valid & id_mem_wr;
      ex_wa         <= id_wa;
      ex_alu_op     <= id_alu_op;
      ex_opa        <= src1;
      ex_opb        <= opb_next;
      ex_store_data <= src2;
    end
  end

`ifdef ID_EX_HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lu_cnt    <= '0;
      stat_flush_cnt <= '0;
    end else if (!ex_hold) begin
      if (flush || flush_pend) begin
        if (stat_flush_cnt != '1)
          stat_flush_cnt <= stat_flush_cnt + 32'd1;
      end else if (lu) begin
        if (stat_lu_cnt != '1)
          stat_lu_cnt <= stat_lu_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
